// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for the seven-segment scan controller: polarity helpers,
// the digit-slice macro and parameter legality checks.
`ifndef SEG_SCAN_MUX_PKG_SV
`define SEG_SCAN_MUX_PKG_SV

`define SEG_SCAN_DIGIT(vec, k, w) vec[(k)*(w) +: (w)]

package seg_scan_mux_pkg;

   function automatic logic en_on_level(input bit activeLow);
      return activeLow ? 1'b0 : 1'b1;
   endfunction

   function automatic bit refresh_div_legal(input int div);
      return div >= 2;
   endfunction

   function automatic bit num_digits_legal(input int n);
      return (n >= 2) && (n <= 8);
   endfunction

endpackage

`endif

// File: rtl/seg_scan_mux_prescaler.sv
// Modulo-DIV free-running counter with a terminal-count flag; shared by the
// scan, blink and debounce blocks.
module scan_prescaler #(
   parameter int DIV = 50000,
   parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      o_tc  = (cnt_q == CNT_W'(DIV - 1));
      cnt_d = o_tc ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit time-multiplexed seven-segment scanner with frame-coherent input
// shadows, leading-zero blanking and a one-cycle dead time per digit slot.
module seg_scan_mux
   import seg_scan_mux_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int DIGIT_W       = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int EN_ACTIVE_LOW = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]   i_digits,
   input  logic [NUM_DIGITS-1:0]           i_dp,
   input  logic [NUM_DIGITS-1:0]           i_blank,
   input  logic                            i_lzb,
   output logic [NUM_DIGITS-1:0]           o_en,
   output logic [DIGIT_W-1:0]              o_seg,
   output logic                            o_dp,
   output logic                            o_blank,
   output logic                            o_frame_tick
);

   localparam int   IDX_W  = $clog2(NUM_DIGITS);
   localparam int   CNT_W  = $clog2(REFRESH_DIV);
   localparam logic EN_ON  = en_on_level(EN_ACTIVE_LOW != 0);
   localparam logic EN_OFF = ~EN_ON;

   if (!refresh_div_legal(REFRESH_DIV)) begin : g_bad_div
      $error("seg_scan_mux: REFRESH_DIV must be >= 2");
   end
   if (!num_digits_legal(NUM_DIGITS)) begin : g_bad_digits
      $error("seg_scan_mux: NUM_DIGITS must be in 2..8");
   end

   logic [CNT_W-1:0]              cnt;
   logic                          tc;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [NUM_DIGITS*DIGIT_W-1:0] shDigits_q;
   logic [NUM_DIGITS-1:0]         shDp_q, shBlank_q;
   logic                          shLzb_q;
   logic                          loadPend_q;
   logic                          loadNow;
   logic [NUM_DIGITS-1:0]         effBlank;
   logic [NUM_DIGITS-1:0]         en_q, en_d;
   logic [DIGIT_W-1:0]            seg_q, seg_d;
   logic                          dp_q, dp_d, blank_q, blank_d, tick_q;

   scan_prescaler #(
      .DIV   (REFRESH_DIV),
      .CNT_W (CNT_W)
   ) u_prescaler (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_cnt   (cnt),
      .o_tc    (tc)
   );

   // A digit is leading-zero blanked when it and every more significant digit is zero.
   assign effBlank[0] = shBlank_q[0];
   for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lzb
      logic zeroFrom;
      if (k == NUM_DIGITS - 1) begin : g_msd
         assign zeroFrom = (`SEG_SCAN_DIGIT(shDigits_q, k, DIGIT_W) == '0);
      end else begin : g_lower
         assign zeroFrom = (`SEG_SCAN_DIGIT(shDigits_q, k, DIGIT_W) == '0) && g_lzb[k+1].zeroFrom;
      end
      assign effBlank[k] = shBlank_q[k] | (shLzb_q & zeroFrom);
   end

   always_comb begin
      loadNow = (tc && (idx_q == IDX_W'(NUM_DIGITS - 1))) || loadPend_q;
      idx_d   = idx_q;
      if (tc) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      seg_d   = `SEG_SCAN_DIGIT(shDigits_q, int'(idx_q), DIGIT_W);
      blank_d = effBlank[idx_q];
      dp_d    = shDp_q[idx_q] & ~blank_d;
      // The first cycle of every slot stays dark so the previous digit cannot ghost.
      en_d    = {NUM_DIGITS{EN_OFF}};
      if ((cnt != '0) && !blank_d) begin
         en_d[idx_q] = EN_ON;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_q      <= '0;
         shDigits_q <= '0;
         shDp_q     <= '0;
         shBlank_q  <= '0;
         shLzb_q    <= 1'b0;
         loadPend_q <= 1'b1;
         en_q       <= {NUM_DIGITS{EN_OFF}};
         seg_q      <= '0;
         dp_q       <= 1'b0;
         blank_q    <= 1'b1;
         tick_q     <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         loadPend_q <= 1'b0;
         tick_q     <= loadNow;
         if (loadNow) begin
            shDigits_q <= i_digits;
            shDp_q     <= i_dp;
            shBlank_q  <= i_blank;
            shLzb_q    <= i_lzb;
         end
         en_q    <= en_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
      end
   end

   assign o_en         = en_q;
   assign o_seg        = seg_q;
   assign o_dp         = dp_q;
   assign o_blank      = blank_q;
   assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: a frame-level scoreboard of expected
// slot outputs, with an active-low and an active-high instance side by side.
module tb_seg_scan_mux;

   localparam int ND = 4;
   localparam int DW = 4;
   localparam int RD = 4;

   typedef struct packed {
      logic [ND-1:0] en;
      logic [DW-1:0] seg;
      logic          dp;
      logic          blank;
      logic          tick;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [ND*DW-1:0] digits;
   logic [ND-1:0] dp;
   logic [ND-1:0] blank;
   logic lzb;

   logic [ND-1:0] enL, enH;
   logic [DW-1:0] segL, segH;
   logic dpL, dpH, blankL, blankH, tickL, tickH;

   exp_t sbQ[$];
   int nChecks = 0;
   int nPassed = 0;

   seg_scan_mux #(.NUM_DIGITS(ND), .DIGIT_W(DW), .REFRESH_DIV(RD), .EN_ACTIVE_LOW(1)) dutL (
      .i_clk(clk), .i_rst_n(rst_n), .i_digits(digits), .i_dp(dp), .i_blank(blank), .i_lzb(lzb),
      .o_en(enL), .o_seg(segL), .o_dp(dpL), .o_blank(blankL), .o_frame_tick(tickL)
   );

   seg_scan_mux #(.NUM_DIGITS(ND), .DIGIT_W(DW), .REFRESH_DIV(RD), .EN_ACTIVE_LOW(0)) dutH (
      .i_clk(clk), .i_rst_n(rst_n), .i_digits(digits), .i_dp(dp), .i_blank(blank), .i_lzb(lzb),
      .o_en(enH), .o_seg(segH), .o_dp(dpH), .o_blank(blankH), .o_frame_tick(tickH)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected active-low outputs for one whole frame, slot by slot.
   function automatic void pushFrame(input logic [ND*DW-1:0] d, input logic [ND-1:0] p,
                                     input logic [ND-1:0] b, input logic z);
      logic [ND-1:0] eff;
      logic leading;
      logic [DW-1:0] dig;
      exp_t e;
      leading = 1'b1;
      for (int k = ND - 1; k >= 0; k--) begin
         dig = d[k*DW +: DW];
         leading = leading && (dig == '0);
         eff[k] = b[k] || (z && (k != 0) && leading);
      end
      for (int j = 0; j < ND * RD; j++) begin
         int k;
         k = j / RD;
         e.seg   = d[k*DW +: DW];
         e.blank = eff[k];
         e.dp    = p[k] && !eff[k];
         e.en    = '1;
         if ((j % RD) != 0 && !eff[k]) e.en[k] = 1'b0;
         e.tick  = (j == ND * RD - 1);
         sbQ.push_back(e);
      end
   endfunction

   task automatic waitTick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tickL !== 1'b1 && n < 100);
      nChecks++;
      if (tickL !== 1'b1) $display("[TB] FAIL frame_tick_timeout got %b want 1", tickL);
      else nPassed++;
   endtask

   task automatic drainFrame(input int changeAt, input logic [ND*DW-1:0] lateDigits);
      exp_t e;
      for (int j = 0; j < ND * RD; j++) begin
         @(negedge clk);
         if (sbQ.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL scoreboard_empty at j=%0d", j);
            return;
         end
         e = sbQ.pop_front();
         nChecks++;
         if (enL !== e.en) $display("[TB] FAIL en j=%0d got %b want %b", j, enL, e.en);
         else nPassed++;
         nChecks++;
         if (enH !== ~e.en) $display("[TB] FAIL en_high_pol j=%0d got %b want %b", j, enH, ~e.en);
         else nPassed++;
         nChecks++;
         if (segL !== e.seg) $display("[TB] FAIL seg j=%0d got %h want %h", j, segL, e.seg);
         else nPassed++;
         nChecks++;
         if (dpL !== e.dp) $display("[TB] FAIL dp j=%0d got %b want %b", j, dpL, e.dp);
         else nPassed++;
         nChecks++;
         if (blankL !== e.blank) $display("[TB] FAIL blank j=%0d got %b want %b", j, blankL, e.blank);
         else nPassed++;
         nChecks++;
         if (tickL !== e.tick) $display("[TB] FAIL frame_tick j=%0d got %b want %b", j, tickL, e.tick);
         else nPassed++;
         if (j == changeAt) digits = lateDigits;
      end
   endtask

   task automatic applyStimulus(input logic [ND*DW-1:0] d, input logic [ND-1:0] p,
                                input logic [ND-1:0] b, input logic z);
      digits = d;
      dp     = p;
      blank  = b;
      lzb    = z;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus(16'h4321, 4'b0000, 4'b0000, 1'b0);
      #12;
      nChecks++;
      if (enL !== 4'b1111 || enH !== 4'b0000) $display("[TB] FAIL reset_en got %b/%b want 1111/0000", enL, enH);
      else nPassed++;
      nChecks++;
      if (segL !== 4'h0 || dpL !== 1'b0 || blankL !== 1'b1 || tickL !== 1'b0)
         $display("[TB] FAIL reset_outs got seg=%h dp=%b blank=%b tick=%b want 0 0 1 0", segL, dpL, blankL, tickL);
      else nPassed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      nChecks++;
      if (tickL !== 1'b1 || enL !== 4'b1111)
         $display("[TB] FAIL first_tick got tick=%b en=%b want 1 1111", tickL, enL);
      else nPassed++;
   endtask

   task automatic test_default_scan();
      applyStimulus(16'h4321, 4'b0000, 4'b0000, 1'b0);
      waitTick();
      pushFrame(16'h4321, 4'b0000, 4'b0000, 1'b0);
      drainFrame(-1, 16'h0);
   endtask

   task automatic test_polarity();
      applyStimulus(16'h4321, 4'b0000, 4'b0000, 1'b0);
      pushFrame(16'h4321, 4'b0000, 4'b0000, 1'b0);
      drainFrame(-1, 16'h0);
   endtask

   task automatic test_lzb();
      applyStimulus(16'h0050, 4'b0000, 4'b0000, 1'b1);
      waitTick();
      pushFrame(16'h0050, 4'b0000, 4'b0000, 1'b1);
      drainFrame(-1, 16'h0);
      applyStimulus(16'h0050, 4'b0000, 4'b0000, 1'b0);
      waitTick();
      pushFrame(16'h0050, 4'b0000, 4'b0000, 1'b0);
      drainFrame(-1, 16'h0);
   endtask

   task automatic test_all_zero();
      applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
      waitTick();
      pushFrame(16'h0000, 4'b0000, 4'b0000, 1'b1);
      drainFrame(-1, 16'h0);
   endtask

   task automatic test_tearing();
      applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
      waitTick();
      pushFrame(16'h1111, 4'b0000, 4'b0000, 1'b0);
      drainFrame(5, 16'h2222);
      pushFrame(16'h2222, 4'b0000, 4'b0000, 1'b0);
      drainFrame(-1, 16'h0);
   endtask

   task automatic test_dp_blank();
      applyStimulus(16'h4321, 4'b0100, 4'b0100, 1'b0);
      waitTick();
      pushFrame(16'h4321, 4'b0100, 4'b0100, 1'b0);
      drainFrame(-1, 16'h0);
      applyStimulus(16'h4321, 4'b0100, 4'b0000, 1'b0);
      waitTick();
      pushFrame(16'h4321, 4'b0100, 4'b0000, 1'b0);
      drainFrame(-1, 16'h0);
   endtask

   task automatic test_async_reset();
      applyStimulus(16'h4321, 4'b0000, 4'b0000, 1'b0);
      waitTick();
      repeat (10) @(negedge clk);
      nChecks++;
      if (enL !== 4'b1011) $display("[TB] FAIL pre_reset_en got %b want 1011", enL);
      else nPassed++;
      #1 rst_n = 1'b0;
      #1;
      nChecks++;
      if (enL !== 4'b1111 || enH !== 4'b0000 || blankL !== 1'b1)
         $display("[TB] FAIL async_reset got en=%b/%b blank=%b want 1111/0000 1", enL, enH, blankL);
      else nPassed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      nChecks++;
      if (tickL !== 1'b1 || enL !== 4'b1111)
         $display("[TB] FAIL restart_dead got tick=%b en=%b want 1 1111", tickL, enL);
      else nPassed++;
      @(negedge clk);
      nChecks++;
      if (enL !== 4'b1110 || segL !== 4'h1 || tickL !== 1'b0)
         $display("[TB] FAIL restart_digit0 got en=%b seg=%h tick=%b want 1110 1 0", enL, segL, tickL);
      else nPassed++;
   endtask

   initial begin
      test_reset();
      test_default_scan();
      test_polarity();
      test_lzb();
      test_all_zero();
      test_tearing();
      test_dp_blank();
      test_async_reset();
      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
